// File: rtl/register_file_pkg.sv
// Shared widths and the rename-table entry type for the register file,
// plus the read-port bypass helper used by both source ports.
package register_file_pkg;

  localparam int REG_POS_WID = 5;
  localparam int ROB_POS_WID = 4;
  localparam int ROB_SIZE    = 16;
  localparam int XLEN        = 32;
  localparam int NUM_REGS    = 1 << REG_POS_WID;

  typedef struct packed {
    logic [XLEN-1:0]        val;
    logic                   busy;
    logic [ROB_POS_WID-1:0] tag;
  } rf_entry_t;

  // A commit landing on a busy entry with a matching tag is forwarded this cycle.
  // A same-cycle issue is deliberately not considered: sources are read before rename.
  function automatic rf_entry_t rf_read_bypass(
    input rf_entry_t              ent,
    input logic [REG_POS_WID-1:0] rs,
    input logic                   cw,
    input logic [REG_POS_WID-1:0] crd,
    input logic [XLEN-1:0]        cval,
    input logic [ROB_POS_WID-1:0] cpos
  );
    rf_entry_t r;
    r = ent;
    if (rs == '0) begin
      r = '0;
    end else if (cw && (crd == rs) && ent.busy && (ent.tag == cpos)) begin
      r.val  = cval;
      r.busy = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Decoder/ROB <-> register file bus: issue rename, source queries, commit write.
interface register_file_if;
  import register_file_pkg::*;

  logic                   rollback;
  logic                   issue;
  logic [REG_POS_WID-1:0] issue_rd;
  logic [ROB_POS_WID-1:0] issue_rob_pos;
  logic [REG_POS_WID-1:0] rs1;
  logic [REG_POS_WID-1:0] rs2;
  logic [XLEN-1:0]        rs1_val;
  logic [XLEN-1:0]        rs2_val;
  logic                   rs1_busy;
  logic                   rs2_busy;
  logic [ROB_POS_WID-1:0] rs1_rob_pos;
  logic [ROB_POS_WID-1:0] rs2_rob_pos;
  logic                   commit_write;
  logic [REG_POS_WID-1:0] commit_rd;
  logic [XLEN-1:0]        commit_val;
  logic [ROB_POS_WID-1:0] commit_rob_pos;

  modport master (
    output rollback, issue, issue_rd, issue_rob_pos, rs1, rs2,
           commit_write, commit_rd, commit_val, commit_rob_pos,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_rob_pos, rs2_rob_pos
  );

  modport slave (
    input  rollback, issue, issue_rd, issue_rob_pos, rs1, rs2,
           commit_write, commit_rd, commit_val, commit_rob_pos,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_rob_pos, rs2_rob_pos
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with rename tags: combinational dual read with
// commit bypass, issue renames rd, commit writes val and retires matching tags.
module register_file
  import register_file_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rdy,
  register_file_if.slave  io_bus
);

  rf_entry_t r_rf [NUM_REGS];
  rf_entry_t w_rd1;
  rf_entry_t w_rd2;
  logic      w_commit;
  logic      w_issue;

  assign w_commit = io_bus.commit_write && (io_bus.commit_rd != '0);
  assign w_issue  = io_bus.issue && (io_bus.issue_rd != '0) && !io_bus.rollback;

  always_comb begin
    w_rd1 = rf_read_bypass(r_rf[io_bus.rs1], io_bus.rs1, io_bus.commit_write,
                           io_bus.commit_rd, io_bus.commit_val, io_bus.commit_rob_pos);
    w_rd2 = rf_read_bypass(r_rf[io_bus.rs2], io_bus.rs2, io_bus.commit_write,
                           io_bus.commit_rd, io_bus.commit_val, io_bus.commit_rob_pos);
  end

  assign io_bus.rs1_val     = w_rd1.val;
  assign io_bus.rs1_busy    = w_rd1.busy;
  assign io_bus.rs1_rob_pos = w_rd1.tag;
  assign io_bus.rs2_val     = w_rd2.val;
  assign io_bus.rs2_busy    = w_rd2.busy;
  assign io_bus.rs2_rob_pos = w_rd2.tag;

  // Entry 0 is only ever cleared, so x0 stays zero without a special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (i_rdy) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_commit && (io_bus.commit_rd == REG_POS_WID'(i)))
          r_rf[i].val <= io_bus.commit_val;
        // Priority: flush, then a fresh rename, then retirement of a matching tag.
        if (io_bus.rollback) begin
          r_rf[i].busy <= 1'b0;
        end else if (w_issue && (io_bus.issue_rd == REG_POS_WID'(i))) begin
          r_rf[i].busy <= 1'b1;
          r_rf[i].tag  <= io_bus.issue_rob_pos;
        end else if (w_commit && (io_bus.commit_rd == REG_POS_WID'(i)) &&
                     (r_rf[i].tag == io_bus.commit_rob_pos)) begin
          r_rf[i].busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural rename-table model.
module tb_register_file;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  register_file_if bus();

  register_file dut (
    .clk    (clk),
    .rst    (rst),
    .i_rdy  (rdy),
    .io_bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance, stated as the architectural rules.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    end else if (rdy) begin
      int crd, ird;
      crd = int'(bus.commit_rd);
      ird = int'(bus.issue_rd);
      if (bus.commit_write && crd != 0) begin
        m_val[crd] = bus.commit_val;
        if (m_tag[crd] == bus.commit_rob_pos) m_busy[crd] = 0;
      end
      if (bus.rollback) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (bus.issue && ird != 0) begin
        m_busy[ird] = 1;
        m_tag[ird]  = bus.issue_rob_pos;
      end
    end
  end

  task automatic model_read(input logic [4:0] rs, output logic [31:0] v, output bit b, output logic [3:0] t);
    int r;
    r = int'(rs);
    v = m_val[r]; b = m_busy[r]; t = m_tag[r];
    if (r == 0) begin
      v = 0; b = 0; t = 0;
    end else if (bus.commit_write && bus.commit_rd == rs && m_busy[r] && m_tag[r] == bus.commit_rob_pos) begin
      v = bus.commit_val; b = 0;
    end
  endtask

  // Compare process: outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] v; bit b; logic [3:0] t;
      model_read(bus.rs1, v, b, t);
      chk("m_rs1_val", bus.rs1_val, v);
      chk("m_rs1_busy", 32'(bus.rs1_busy), 32'(b));
      if (b) chk("m_rs1_pos", 32'(bus.rs1_rob_pos), 32'(t));
      model_read(bus.rs2, v, b, t);
      chk("m_rs2_val", bus.rs2_val, v);
      chk("m_rs2_busy", 32'(bus.rs2_busy), 32'(b));
      if (b) chk("m_rs2_pos", 32'(bus.rs2_rob_pos), 32'(t));
    end
  end

  task automatic idle();
    bus.rollback = 0; bus.issue = 0; bus.issue_rd = 0; bus.issue_rob_pos = 0;
    bus.commit_write = 0; bus.commit_rd = 0; bus.commit_val = 0; bus.commit_rob_pos = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic issue(input int rd, input int tag);
    bus.issue = 1; bus.issue_rd = 5'(rd); bus.issue_rob_pos = 4'(tag);
  endtask

  task automatic commit(input int rd, input int tag, input logic [31:0] v);
    bus.commit_write = 1; bus.commit_rd = 5'(rd); bus.commit_rob_pos = 4'(tag); bus.commit_val = v;
  endtask

  // Literal check of port 1 at the next sampling point (inputs already driven).
  task automatic lit1(input string name, input logic [31:0] v, input bit b, input logic [3:0] t, input bit ck_t);
    @(negedge clk);
    chk({name, "_val"}, bus.rs1_val, v);
    chk({name, "_busy"}, 32'(bus.rs1_busy), 32'(b));
    if (ck_t) chk({name, "_pos"}, 32'(bus.rs1_rob_pos), 32'(t));
  endtask

  initial begin
    idle();
    rst = 1; rdy = 1; bus.rs1 = 0; bus.rs2 = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    chk_en = 1;

    // Reset state on both ports.
    bus.rs1 = 5; bus.rs2 = 0;
    @(negedge clk);
    chk("rst_rs1_val", bus.rs1_val, 0);
    chk("rst_rs1_busy", 32'(bus.rs1_busy), 0);
    chk("rst_rs1_pos", 32'(bus.rs1_rob_pos), 0);
    chk("rst_rs2_val", bus.rs2_val, 0);
    chk("rst_rs2_busy", 32'(bus.rs2_busy), 0);
    chk("rst_rs2_pos", 32'(bus.rs2_rob_pos), 0);
    step();

    // Rename then commit with same-cycle bypass.
    issue(3, 7); step();
    bus.rs1 = 3;
    lit1("iss3", 0, 1, 7, 1);
    step();
    commit(3, 7, 32'hDEADBEEF);
    lit1("byp3", 32'hDEADBEEF, 0, 0, 0);
    step();
    lit1("st3", 32'hDEADBEEF, 0, 0, 0);

    // Stale-tag commit updates value only.
    issue(4, 2); step();
    issue(4, 9); step();
    commit(4, 2, 32'h11); bus.rs1 = 4;
    lit1("stale4_cyc", 0, 1, 9, 1);
    step();
    lit1("stale4", 32'h11, 1, 9, 1);

    // Issue and commit to the same register: issue keeps busy with new tag.
    issue(6, 1); step();
    issue(6, 5); commit(6, 1, 32'h22); step();
    bus.rs1 = 6;
    lit1("iss_cmt6", 32'h22, 1, 5, 1);

    // Rollback with coincident commit and issue.
    issue(1, 3); commit(1, 0, 32'hAA); step();
    issue(2, 4); step();
    bus.rollback = 1; commit(8, 0, 32'h33); issue(10, 6); step();
    bus.rs1 = 1; lit1("rb_x1", 32'hAA, 0, 0, 0);
    bus.rs1 = 2; lit1("rb_x2", 0, 0, 0, 0);
    bus.rs1 = 8; lit1("rb_x8", 32'h33, 0, 0, 0);
    bus.rs1 = 10; lit1("rb_x10", 0, 0, 0, 0);
    step();

    // x0 immune to issue and commit; rdy low holds state.
    issue(0, 1); commit(0, 1, 32'hFF); step();
    bus.rs1 = 0;
    lit1("x0", 0, 0, 0, 1);
    rdy = 0; commit(9, 0, 32'h99); bus.rs1 = 9;
    lit1("hold9_a", 0, 0, 0, 0);
    @(posedge clk); #1;
    lit1("hold9_b", 0, 0, 0, 0);
    @(posedge clk); #1;
    rdy = 1;
    @(posedge clk); #1;
    idle();
    lit1("rel9", 32'h99, 0, 0, 0);
    step();

    // Randomized traffic; small register window to force collisions.
    for (int n = 0; n < 1500; n++) begin
      int crd;
      rdy = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 199) == 0);
      bus.rollback = ($urandom_range(0, 15) == 0);
      bus.issue = $urandom_range(0, 1);
      bus.issue_rd = 5'($urandom_range(0, 9));
      bus.issue_rob_pos = 4'($urandom);
      crd = $urandom_range(0, 9);
      bus.commit_write = $urandom_range(0, 1);
      bus.commit_rd = 5'(crd);
      bus.commit_val = $urandom;
      bus.commit_rob_pos = ($urandom_range(0, 3) != 0) ? m_tag[crd] : 4'($urandom);
      bus.rs1 = ($urandom_range(0, 1) != 0) ? 5'(crd) : 5'($urandom_range(0, 31));
      bus.rs2 = 5'($urandom_range(0, 9));
      @(posedge clk); #1;
    end

    // Reset takes priority over everything else at the edge.
    rst = 1; rdy = 0; bus.rollback = 1; issue(5, 3); commit(5, 3, 32'h5);
    @(posedge clk); #1;
    rst = 0; rdy = 1; idle(); bus.rs1 = 5; bus.rs2 = 9;
    @(negedge clk);
    chk("rst2_rs1_val", bus.rs1_val, 0);
    chk("rst2_rs1_busy", 32'(bus.rs1_busy), 0);
    chk("rst2_rs2_val", bus.rs2_val, 0);
    chk("rst2_rs2_pos", 32'(bus.rs2_rob_pos), 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
